// File: rtl/gpio_host_seq.sv
// Host-side GPIO sequencer: drives the ControlBlock GPIO word through reset, kernel, length,
// data and run phases, then waits for EOP. Optional EOP watchdog under GPIO_HOST_TIMEOUT_EN.
module gpio_host_seq #(
  parameter int GPIO_D      = 32,
  parameter int BIT_LEN     = 8,
  parameter int M_LEN       = 3,
  parameter int BITS_IMAGE  = 10,
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                            i_CLK,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic [M_LEN*M_LEN*BIT_LEN-1:0]  i_kernel,
  input  logic [BITS_IMAGE-1:0]           i_img_len,
  input  logic [23:0]                     i_pix_data,
  input  logic                            i_pix_valid,
  output logic                            o_pix_ready,
  input  logic                            i_eop,
  input  logic [GPIO_D-1:0]               i_gpio_rd,
  output logic [GPIO_D-1:0]               o_gpio,
  output logic [GPIO_D-1:0]               o_status,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err
);
  localparam int WORD_W = M_LEN * BIT_LEN;
  localparam int KERN_W = M_LEN * WORD_W;
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [BITS_IMAGE-1:0] KLAST = BITS_IMAGE'(M_LEN - 1);
  localparam logic [2:0] CTRL_KERNEL = 3'b001;
  localparam logic [2:0] CTRL_LENGTH = 3'b010;
  localparam logic [2:0] CTRL_DATA   = 3'b011;
  localparam logic [2:0] CTRL_RUN    = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_RSTP, S_KERNEL, S_LENGTH, S_DATA, S_RUN, S_WAIT_EOP
  } state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_RELEASE, PH_ACCEPT} phase_t;

  state_t                 state_q, state_d;
  phase_t                 phase_q, phase_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [BITS_IMAGE-1:0]  word_q, word_d;
  logic [BITS_IMAGE-1:0]  len_q, len_d;
  logic [KERN_W-1:0]      kern_q, kern_d;
  logic [23:0]            pix_q, pix_d;
  logic [GPIO_D-1:0]      gpio_q, gpio_d;
  logic [GPIO_D-1:0]      status_q, status_d;
  logic                   done_q, done_d;
  logic                   hold_last, start_acc, to_hit;
  logic [2:0]             ctrl;
  logic [23:0]            wdata;
  logic [31:0]            gpio32;

  assign hold_last = (hold_q == HOLD_W'(HOLD_CYC - 1));
  assign start_acc = (state_q == S_IDLE) && i_start;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    word_d      = word_q;
    len_d       = len_q;
    kern_d      = kern_q;
    pix_d       = pix_q;
    status_d    = status_q;
    done_d      = 1'b0;
    o_pix_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_RSTP;
          hold_d  = '0;
          word_d  = '0;
          len_d   = i_img_len;
          kern_d  = i_kernel;
        end
      end
      S_RSTP: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_last) begin
          hold_d  = '0;
          state_d = S_KERNEL;
          phase_d = PH_SETUP;
        end
      end
      S_WAIT_EOP: begin
        if (i_eop) begin
          status_d = i_gpio_rd;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else if (to_hit) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        if (phase_q == PH_ACCEPT) begin
          // Data word handshake: the word is captured in the cycle valid&ready is seen.
          if (i_pix_valid) begin
            o_pix_ready = 1'b1;
            pix_d       = i_pix_data;
            phase_d     = PH_SETUP;
            hold_d      = '0;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_last) begin
            hold_d = '0;
            case (phase_q)
              PH_SETUP:  phase_d = PH_STROBE;
              PH_STROBE: phase_d = PH_RELEASE;
              default: begin
                phase_d = PH_SETUP;
                case (state_q)
                  S_KERNEL: begin
                    kern_d = kern_q >> WORD_W;
                    if (word_q == KLAST) begin
                      word_d  = '0;
                      state_d = S_LENGTH;
                    end else begin
                      word_d = word_q + BITS_IMAGE'(1);
                    end
                  end
                  S_LENGTH: begin
                    word_d = '0;
                    if (len_q == '0) begin
                      state_d = S_RUN;
                    end else begin
                      state_d = S_DATA;
                      phase_d = PH_ACCEPT;
                    end
                  end
                  S_DATA: begin
                    if (word_q == len_q - BITS_IMAGE'(1)) begin
                      state_d = S_RUN;
                    end else begin
                      word_d  = word_q + BITS_IMAGE'(1);
                      phase_d = PH_ACCEPT;
                    end
                  end
                  S_RUN:   state_d = S_WAIT_EOP;
                  default: state_d = S_IDLE;
                endcase
              end
            endcase
          end
        end
      end
    endcase
  end

  // The GPIO word is built from next-state values so o_gpio is a plain register.
  always_comb begin
    ctrl   = 3'b000;
    wdata  = '0;
    gpio32 = '0;
    case (state_d)
      S_KERNEL: begin ctrl = CTRL_KERNEL; wdata = 24'(kern_d[WORD_W-1:0]); end
      S_LENGTH: begin ctrl = CTRL_LENGTH; wdata = 24'(len_d); end
      S_DATA:   begin ctrl = CTRL_DATA;   wdata = pix_d; end
      S_RUN:    begin ctrl = CTRL_RUN;    wdata = '0; end
      default:  begin ctrl = 3'b000;      wdata = '0; end
    endcase
    if (state_d == S_RSTP) begin
      gpio32 = 32'h1;
    end else if (ctrl != 3'b000 && phase_d != PH_ACCEPT) begin
      gpio32 = {ctrl, (phase_d == PH_STROBE), 3'b000, wdata, 1'b0};
    end
    gpio_d = GPIO_D'(gpio32);
  end

  always_ff @(posedge i_CLK or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      phase_q  <= PH_SETUP;
      hold_q   <= '0;
      word_q   <= '0;
      gpio_q   <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      word_q   <= word_d;
      gpio_q   <= gpio_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge i_CLK) begin
    len_q  <= len_d;
    kern_q <= kern_d;
    pix_q  <= pix_d;
  end

`ifdef GPIO_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;

  assign to_hit = (to_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    to_d  = (state_q == S_WAIT_EOP) ? to_q + TO_W'(1) : '0;
    err_d = err_q;
    if (start_acc) begin
      err_d = 1'b0;
    end else if (state_q == S_WAIT_EOP && !i_eop && to_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_CLK or posedge i_rst) begin
    if (i_rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign to_hit = 1'b0;
  assign o_err  = 1'b0;
`endif

  assign o_gpio   = gpio_q;
  assign o_status = status_q;
  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = done_q;
endmodule

// File: tb/tb_gpio_host_seq.sv
// Bench for gpio_host_seq: table-driven and randomized sequences compared cycle by cycle
// against an expected GPIO trace built from the word-level protocol description.
module tb_gpio_host_seq;
  localparam int H  = 2;
  localparam int M  = 3;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst, start, pix_valid, pix_ready, eop, busy, done, err;
  logic [71:0] kernel;
  logic [9:0]  img_len;
  logic [23:0] pix_data;
  logic [31:0] gpio_rd, gpio, status;

  always #5 clk = ~clk;

  gpio_host_seq #(
    .GPIO_D(32), .BIT_LEN(8), .M_LEN(M), .BITS_IMAGE(10), .HOLD_CYC(H), .TIMEOUT_CYC(TO)
  ) dut (
    .i_CLK(clk), .i_rst(rst), .i_start(start), .i_kernel(kernel), .i_img_len(img_len),
    .i_pix_data(pix_data), .i_pix_valid(pix_valid), .o_pix_ready(pix_ready),
    .i_eop(eop), .i_gpio_rd(gpio_rd), .o_gpio(gpio), .o_status(status),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [71:0] kern;
    int          len;
    int          stall_w;
    int          stall_c;
    int          eop_dly;
    logic [31:0] rd;
    int          again;
    int          exp_cyc;
  } vec_t;

  logic [31:0] exp_q[$];
  logic [23:0] pix[$];

  function automatic logic [31:0] enc(input logic [2:0] c, input logic v, input logic [23:0] d);
    return {c, v, 3'b000, d, 1'b0};
  endfunction

  task automatic push_word(input logic [2:0] c, input logic [23:0] d);
    for (int i = 0; i < H; i++) exp_q.push_back(enc(c, 1'b0, d));
    for (int i = 0; i < H; i++) exp_q.push_back(enc(c, 1'b1, d));
    for (int i = 0; i < H; i++) exp_q.push_back(enc(c, 1'b0, d));
  endtask

  // Expected o_gpio per cycle from start+1 through the last RUN cycle.
  task automatic build_model(input vec_t v);
    int z;
    exp_q.delete();
    for (int i = 0; i < H; i++) exp_q.push_back(32'h1);
    for (int k = 0; k < M; k++) push_word(3'd1, v.kern[24*k +: 24]);
    push_word(3'd2, 24'(v.len));
    for (int j = 0; j < v.len; j++) begin
      z = 1 + ((j == v.stall_w) ? v.stall_c : 0);
      for (int i = 0; i < z; i++) exp_q.push_back(32'h0);
      push_word(3'd3, pix[j]);
    end
    push_word(3'd4, 24'h0);
  endtask

  task automatic run_seq(input string nm, input vec_t v, input bit tmo);
    logic [31:0] act[$];
    logic [31:0] prev_status, st_de;
    logic        busy_de, err_de;
    int L, c_e, de, ncyc, idx, stall_cnt, acc, dones, bad, last_nz, zbad;
    pix.delete();
    for (int j = 0; j < v.len; j++) pix.push_back(24'($urandom()));
    build_model(v);
    L     = exp_q.size();
    c_e   = tmo ? -1 : L + v.eop_dly;
    de    = tmo ? L + TO : L + v.eop_dly + 1;
    ncyc  = de + 2;
    idx = 0; stall_cnt = 0; acc = 0; dones = 0;
    st_de = '0; busy_de = 1'b0; err_de = 1'b0;
    @(negedge clk);
    prev_status = status;
    kernel  = v.kern;
    img_len = 10'(v.len);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    kernel  = ~v.kern;
    img_len = ~(10'(v.len));
    chk({nm, " busy_after_start"}, {31'b0, busy}, 32'd1);
    chk({nm, " err_after_start"}, {31'b0, err}, 32'd0);
    for (int c = 0; c < ncyc; c++) begin
      act.push_back(gpio);
      if (done === 1'b1) dones++;
      if (c == de) begin st_de = status; busy_de = busy; err_de = err; end
      start     = (c == v.again);
      eop       = (c == c_e);
      gpio_rd   = eop ? v.rd : $urandom();
      pix_valid = (stall_cnt == 0) && (idx < v.len);
      pix_data  = pix_valid ? pix[idx] : 24'($urandom());
      #1;
      if (stall_cnt > 0) stall_cnt--;
      if (pix_ready === 1'b1) begin
        acc++;
        if (pix_valid) begin
          idx++;
          if (idx == v.stall_w && v.stall_c > 0) stall_cnt = 3*H + v.stall_c;
        end
      end
      @(negedge clk);
    end
    start = 1'b0; eop = 1'b0; pix_valid = 1'b0;
    bad = -1;
    for (int c = 0; c < L; c++) if (act[c] !== exp_q[c] && bad < 0) bad = c;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s trace@%0d: got %h, expected %h", nm, bad, act[bad], exp_q[bad]);
    end
    zbad = 0;
    for (int c = L; c < ncyc; c++) if (act[c] !== 32'h0) zbad++;
    chk({nm, " wait_eop_gpio_nonzero"}, zbad, 0);
    last_nz = -1;
    for (int c = 0; c < ncyc; c++) if (act[c] !== 32'h0) last_nz = c;
    chk({nm, " seq_len"}, last_nz + 1, (v.exp_cyc > 0) ? v.exp_cyc : L);
    chk({nm, " accepts"}, acc, v.len);
    chk({nm, " done_pulses"}, dones, 1);
    chk({nm, " status"}, st_de, tmo ? prev_status : v.rd);
    chk({nm, " busy_at_done"}, {31'b0, busy_de}, 32'd0);
    chk({nm, " err_at_done"}, {31'b0, err_de}, tmo ? 32'd1 : 32'd0);
  endtask

  task automatic idle_chk(input string nm, input int n);
    int bad;
    bad = 0;
    pix_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (gpio !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || pix_ready !== 1'b0) bad++;
    end
    pix_valid = 1'b0;
    chk({nm, " idle_activity"}, bad, 0);
  endtask

  vec_t vt[5];
  vec_t rv;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    vt[0] = '{72'h070809_040506_010203, 4, -1, 0, 3, 32'hA5A5_0001, -1, 60};
    vt[1] = '{72'h070809_040506_010203, 4,  2, 10, 2, 32'h1234_5678, -1, 70};
    vt[2] = '{72'h0A0B0C_0D0E0F_102030, 0, -1, 0, 5, 32'h0000_BEEF, -1, 32};
    vt[3] = '{72'h070809_040506_010203, 4, -1, 0, 1, 32'h5A5A_0002, 30, 60};
    vt[4] = '{72'hFFFFFF_800000_000001, 1, -1, 0, 0, 32'hDEAD_C0DE, -1, 39};

    rst = 1'b1; start = 1'b0; kernel = '0; img_len = '0; pix_data = '0;
    pix_valid = 1'b0; eop = 1'b0; gpio_rd = '0;
    #12;
    chk("reset gpio", gpio, 32'h0);
    chk("reset status", status, 32'h0);
    chk("reset busy_done_err_ready", {28'b0, busy, done, err, pix_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_chk("post_reset", 20);

`ifdef GPIO_HOST_TIMEOUT_EN
    run_seq("timeout", '{72'h030201_060504_090807, 2, -1, 0, 0, 32'hFFFF_FFFF, -1, 0}, 1'b1);
`endif

    for (int i = 0; i < 5; i++) run_seq($sformatf("vec%0d", i), vt[i], 1'b0);

    for (int i = 0; i < 6; i++) begin
      rv.kern    = 72'({$urandom(), $urandom(), $urandom()});
      rv.len     = $urandom_range(0, 6);
      rv.stall_w = $urandom_range(1, 5);
      rv.stall_c = $urandom_range(0, 8);
      rv.eop_dly = $urandom_range(0, 10);
      rv.rd      = $urandom();
      rv.again   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1;
      rv.exp_cyc = 0;
      run_seq($sformatf("rand%0d", i), rv, 1'b0);
    end

    // Abort in the middle of a data word.
    @(negedge clk);
    kernel = 72'h070809_040506_010203; img_len = 10'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; pix_valid = 1'b1; pix_data = 24'h55AA55;
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst gpio", gpio, 32'h0);
    chk("midrst status", status, 32'h0);
    chk("midrst busy_done_err", {29'b0, busy, done, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_chk("post_midrst", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_host_seq.md
# gpio_host_seq

Host-side GPIO sequencer that drives the 32-bit GPIO control word consumed by the convolution `ControlBlock`, replacing the processor as initiator. It issues one configuration transaction sequence per start request: downstream reset pulse, kernel load, image-length load, image data stream, and run command. It then waits for end-of-processing and latches the block's GPIO readback. It sits between a local pixel source (bench or DMA stub) and the `ControlBlock` GPIO input.

## Interface
- `GPIO_D`, 32, GPIO word width.
- `BIT_LEN`, 8, kernel coefficient width.
- `M_LEN`, 3, kernel side; `M_LEN` words of `M_LEN*BIT_LEN` bits.
- `BITS_IMAGE`, 10, image-length width.
- `HOLD_CYC`, 4, cycles per handshake phase, ≥1.
- `TIMEOUT_CYC`, 65535, EOP watchdog limit; used only with the macro.

Ports:
- `i_CLK`  in  1  clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  one-cycle start request; sampled only in IDLE.
- `i_kernel`  in  M_LEN*M_LEN*BIT_LEN  kernel; word k = bits [24k+23:24k]; sampled on start.
- `i_img_len`  in  BITS_IMAGE  number of data words; sampled on start.
- `i_pix_data`  in  24  data word.
- `i_pix_valid`  in  1  data word available.
- `o_pix_ready`  out  1  one-cycle accept; word taken when valid&ready.
- `i_eop`  in  1  end-of-processing from ControlBlock.
- `i_gpio_rd`  in  GPIO_D  ControlBlock GPIO readback.
- `o_gpio`  out  GPIO_D  bit0 downstream reset, [24:1] data, [27:25] zero, [28] valid, [31:29] ctrl.
- `o_status`  out  GPIO_D  readback latched at EOP.
- `o_busy`  out  1  high outside IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  sticky timeout flag; cleared on start.

## Operation
- Ctrl codes: KERNEL=3'b001, LENGTH=3'b010, DATA=3'b011, RUN=3'b100; 3'b000 idle.
- States: IDLE → RSTP → KERNEL → LENGTH → DATA → RUN → WAIT_EOP → IDLE.
- RSTP: `o_gpio[0]`=1 for HOLD_CYC cycles, other bits 0.
- Word transfer, three phases of HOLD_CYC cycles each: SETUP (ctrl and data driven, valid=0), STROBE (valid=1), RELEASE (valid=0, ctrl and data held). The next word's SETUP follows immediately.
- KERNEL: M_LEN words, index 0 first, data = kernel word.
- LENGTH: one word, data = zero-extended latched length.
- DATA: latched-length words. Each SETUP is entered only after a valid&ready accept. `o_pix_ready` pulses on the first cycle that state is waiting and `i_pix_valid`=1. While valid=0 the block stalls with `o_gpio`=0.
- A latched length of 0 skips DATA.
- RUN: one word, data=0.
- WAIT_EOP: `o_gpio`=0. When `i_eop`=1: `o_status`←`i_gpio_rd`, `o_done` pulses the next cycle, return to IDLE.
- `i_start` outside IDLE is ignored.
- All internal counters are sized for their maximum value, with no wrap. The word counter is BITS_IMAGE bits wide and compares against the latched length.

## Timing
- Reset values: `o_gpio`=0, `o_status`=0, `o_busy`=0, `o_done`=0, `o_err`=0, `o_pix_ready`=0, state IDLE.
- Reset mid-sequence aborts immediately. `o_gpio` returns to 0 asynchronously.
- `i_start` at cycle t puts RSTP on `o_gpio` at t+1; `o_busy` rises at t+1.
- Each word takes 3*HOLD_CYC cycles.
- With the pixel source always valid, each data word adds one accept cycle.
- `o_done` is asserted one cycle after `i_eop` is sampled.
- `o_gpio` is fully registered, with no combinational path from inputs.

## Configuration
- `GPIO_HOST_TIMEOUT_EN` defined:
  - a WAIT_EOP counter runs;
  - reaching TIMEOUT_CYC cycles without `i_eop` sets `o_err`, pulses `o_done`, leaves `o_status` unchanged, and returns to IDLE.
- Undefined: WAIT_EOP waits indefinitely and `o_err` is tied 0.

## Test plan
- Reset/idle: assert `i_rst` mid-DATA → `o_gpio`=0 immediately, `o_busy`=0; no output activity without start.
- Full sequence, HOLD_CYC=2, len=4, kernel words 0x010203/0x040506/0x070809, pixel source always valid:
  - bit0 high for 2 cycles;
  - 3 KERNEL words, then LENGTH data=4, 4 DATA words, RUN;
  - each strobe lasts exactly 2 cycles;
  - `i_eop` with readback 0xA5A5_0001 → `o_status`=0xA5A5_0001 and `o_done` pulses once.
- Pixel stall: valid low 10 cycles before word 2 → `o_gpio`=0 during the stall, words stay in order, word count still 4.
- len=0 → RUN follows LENGTH directly; `o_pix_ready` never asserts.
- Start while busy → ignored; the sequence and word count are unchanged.
- With `GPIO_HOST_TIMEOUT_EN`, TIMEOUT_CYC=100, no `i_eop` → `o_err`=1 and `o_done` pulses 100 cycles into WAIT_EOP; the next start clears `o_err`.
